mem_access_unit: RTL

Memory-stage access controller for the pipelined MIPS CPU. Sits directly upstream of the 8K-word data-memory block RAM (4-bit byte-write-enable, synchronous read) and downstream of the EX/MEM pipeline register. Turns a load/store request into BRAM word address, byte enables and lane-aligned write data, and checks alignment and range. Tracks the one-cycle BRAM read latency and returns sign/zero-extended load data with a valid flag.

---
 rtl/mem_access_unit_if.sv | 32 +++
 rtl/mem_access_unit.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/mem_access_unit_if.sv
// Bundle of the pipeline request, data-memory BRAM port and load/exception
// results seen by the memory-stage access controller.
interface mem_access_unit_if #(
  parameter int AW = 13
);
  logic          req_valid;
  logic          flush;
  logic [5:0]    opcode;
  logic [31:0]   addr;
  logic [31:0]   store_data;
  logic [AW-1:0] bram_addr;
  logic [3:0]    bram_wea;
  logic [31:0]   bram_din;
  logic [31:0]   bram_dout;
  logic [31:0]   load_data;
  logic          load_valid;
  logic          exc_valid;
  logic [4:0]    exc_code;
  logic [31:0]   exc_badvaddr;

  modport master (
    output req_valid, flush, opcode, addr, store_data, bram_dout,
    input  bram_addr, bram_wea, bram_din, load_data, load_valid,
           exc_valid, exc_code, exc_badvaddr
  );

  modport slave (
    input  req_valid, flush, opcode, addr, store_data, bram_dout,
    output bram_addr, bram_wea, bram_din, load_data, load_valid,
           exc_valid, exc_code, exc_badvaddr
  );
endinterface

// File: rtl/mem_access_unit.sv
// Memory-stage access controller: maps MIPS loads/stores onto a byte-enabled,
// synchronous-read BRAM, checks alignment/range and returns extended load data.
module mem_access_unit #(
  parameter int DM_WORDS = 8192,
  parameter int AW       = 13
) (
  input logic              clk,
  input logic              reset,
  mem_access_unit_if.slave bus
);
  localparam logic [5:0]  OP_LB  = 6'd32;
  localparam logic [5:0]  OP_LH  = 6'd33;
  localparam logic [5:0]  OP_LW  = 6'd35;
  localparam logic [5:0]  OP_LBU = 6'd36;
  localparam logic [5:0]  OP_LHU = 6'd37;
  localparam logic [5:0]  OP_SB  = 6'd40;
  localparam logic [5:0]  OP_SH  = 6'd41;
  localparam logic [5:0]  OP_SW  = 6'd43;
  localparam logic [4:0]  EXC_ADEL   = 5'd4;
  localparam logic [4:0]  EXC_ADES   = 5'd5;
  localparam logic [32:0] ADDR_LIMIT = 33'(4 * DM_WORDS);

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } size_e;

  typedef struct packed {
    logic       is_load;
    logic       is_signed;
    size_e      size;
    logic [1:0] off;
  } pend_t;

  logic        known;
  logic        is_load;
  logic        is_signed;
  size_e       size;
  logic [1:0]  off;
  logic        accept;
  logic        misaligned;
  logic        out_of_range;
  logic        fault;
  pend_t       pend_q;
  logic        exc_valid_q;
  logic [4:0]  exc_code_q;
  logic [31:0] exc_badvaddr_q;
  logic [7:0]  lane_byte;
  logic [15:0] lane_half;

  always_comb begin
    known     = 1'b1;
    is_load   = 1'b0;
    is_signed = 1'b0;
    size      = SZ_WORD;
    case (bus.opcode)
      OP_LB:  begin is_load = 1'b1; is_signed = 1'b1; size = SZ_BYTE; end
      OP_LH:  begin is_load = 1'b1; is_signed = 1'b1; size = SZ_HALF; end
      OP_LW:  begin is_load = 1'b1; size = SZ_WORD; end
      OP_LBU: begin is_load = 1'b1; size = SZ_BYTE; end
      OP_LHU: begin is_load = 1'b1; size = SZ_HALF; end
      OP_SB:  size = SZ_BYTE;
      OP_SH:  size = SZ_HALF;
      OP_SW:  size = SZ_WORD;
      default: known = 1'b0;
    endcase
  end

  assign off          = bus.addr[1:0];
  assign accept       = bus.req_valid & ~bus.flush & ~reset & known;
  assign misaligned   = ((size == SZ_HALF) && off[0]) || ((size == SZ_WORD) && (off != 2'b00));
  assign out_of_range = {1'b0, bus.addr} >= ADDR_LIMIT;
  assign fault        = accept & (misaligned | out_of_range);

  // The read port follows the address every cycle; a stray read is harmless.
  assign bus.bram_addr = bus.addr[AW+1:2];

  always_comb begin
    bus.bram_wea = 4'b0000;
    bus.bram_din = 32'h0000_0000;
    if (accept && !fault && !is_load) begin
      case (size)
        SZ_BYTE: begin
          bus.bram_wea = 4'b0001 << off;
          bus.bram_din = {24'h00_0000, bus.store_data[7:0]} << {off, 3'b000};
        end
        SZ_HALF: begin
          if (off[1]) begin
            bus.bram_wea = 4'b1100;
            bus.bram_din = {bus.store_data[15:0], 16'h0000};
          end else begin
            bus.bram_wea = 4'b0011;
            bus.bram_din = {16'h0000, bus.store_data[15:0]};
          end
        end
        default: begin
          bus.bram_wea = 4'b1111;
          bus.bram_din = bus.store_data;
        end
      endcase
    end
  end

  // Faulting or cancelled loads leave the pending register clear, so they never yield a result.
  always_ff @(posedge clk) begin
    if (reset) begin
      pend_q         <= '0;
      exc_valid_q    <= 1'b0;
      exc_code_q     <= 5'd0;
      exc_badvaddr_q <= 32'h0000_0000;
    end else begin
      pend_q         <= '0;
      exc_valid_q    <= 1'b0;
      exc_code_q     <= 5'd0;
      exc_badvaddr_q <= 32'h0000_0000;
      if (accept && !fault && is_load) begin
        pend_q <= '{is_load: 1'b1, is_signed: is_signed, size: size, off: off};
      end
      if (fault) begin
        exc_valid_q    <= 1'b1;
        exc_code_q     <= is_load ? EXC_ADEL : EXC_ADES;
        exc_badvaddr_q <= bus.addr;
      end
    end
  end

  assign lane_byte = bus.bram_dout[{pend_q.off, 3'b000} +: 8];
  assign lane_half = bus.bram_dout[{pend_q.off[1], 4'b0000} +: 16];

  always_comb begin
    bus.load_data = 32'h0000_0000;
    if (pend_q.is_load) begin
      case (pend_q.size)
        SZ_BYTE: bus.load_data = {{24{pend_q.is_signed & lane_byte[7]}}, lane_byte};
        SZ_HALF: bus.load_data = {{16{pend_q.is_signed & lane_half[15]}}, lane_half};
        default: bus.load_data = bus.bram_dout;
      endcase
    end
  end

  assign bus.load_valid   = pend_q.is_load;
  assign bus.exc_valid    = exc_valid_q;
  assign bus.exc_code     = exc_code_q;
  assign bus.exc_badvaddr = exc_badvaddr_q;
endmodule
